// File: rtl/frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
package frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StDath,
    StDatl,
    StChk
  } state_e;

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned FRAME_LEN = 5;

endpackage

// File: rtl/rx_byte_strobe.sv
// One-cycle strobe on each rising edge of the receiver's byte-ready flag.
module rx_byte_strobe (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic byte_rdy_i,
  output logic strb_o
);

  logic byte_rdy_q, byte_rdy_d;

  always_comb begin
    byte_rdy_d = byte_rdy_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_rdy_q <= 1'b0;
    end else begin
      byte_rdy_q <= byte_rdy_d;
    end
  end

  assign strb_o = byte_rdy_i & ~byte_rdy_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/ADDR/DATA_H/DATA_L/CHK frames, checks the XOR sum and issues register writes.
module uart_frame_parser
  import frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_Rx,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_rdy,
  output logic             wr_en,
  output logic [7:0]       wr_addr,
  output logic [15:0]      wr_data,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

  logic strb;

  rx_byte_strobe u_strobe (
    .clk_i      (clk_Rx),
    .rst_ni     (rst_n),
    .byte_rdy_i (byte_rdy),
    .strb_o     (strb)
  );

  state_e           state_q, state_d;
  logic [TmrW-1:0]  timer_q, timer_d;
  logic [7:0]       addr_q, addr_d, dh_q, dh_d, dl_q, dl_d, chk_q, chk_d;
  logic             wr_en_q, wr_en_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] err_cnt_inc;

  assign err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dh_d        = dh_q;
    dl_d        = dl_q;
    chk_d       = chk_q;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_code_d  = err_code_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    timer_d     = (state_q == StIdle || strb) ? '0 : timer_q + TmrW'(1);

    unique case (state_q)
      StIdle: if (strb && byte_in == SYNC_BYTE) state_d = StAddr;
      StAddr: if (strb) begin
        addr_d  = byte_in;
        chk_d   = byte_in;
        state_d = StDath;
      end
      StDath: if (strb) begin
        dh_d    = byte_in;
        chk_d   = chk_q ^ byte_in;
        state_d = StDatl;
      end
      StDatl: if (strb) begin
        dl_d    = byte_in;
        chk_d   = chk_q ^ byte_in;
        state_d = StChk;
      end
      StChk: if (strb) begin
        state_d = StIdle;
        if (byte_in == chk_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {dh_q, dl_q};
          ok_cnt_d  = ok_cnt_q + CNT_W'(1);
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_CHK;
          err_cnt_d   = err_cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    // A strobe in the expiry cycle takes priority over the timeout.
    if (state_q != StIdle && !strb && timer_q == TmrLast) begin
      state_d     = StIdle;
      timer_d     = '0;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
      err_cnt_d   = err_cnt_inc;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_Rx or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      addr_q      <= '0;
      dh_q        <= '0;
      dl_q        <= '0;
      chk_q       <= '0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_code_q  <= '0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      dh_q        <= dh_d;
      dl_q        <= dl_d;
      chk_q       <= chk_d;
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_code_q  <= err_code_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;
  assign busy          = busy_q;
  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized frames checked every cycle against a frame-level reference model.
module tb_uart_frame_parser;

  localparam int unsigned Tmo = 100;
  localparam int unsigned Cw  = 4;

  logic          clk_Rx = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_rdy = 1'b0;
  logic          wr_en, frame_err, busy;
  logic [7:0]    wr_addr;
  logic [15:0]   wr_data;
  logic [1:0]    err_code;
  logic [Cw-1:0] frame_ok_cnt, frame_err_cnt;

  uart_frame_parser #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (Tmo),
    .CNT_W       (Cw)
  ) dut (
    .clk_Rx        (clk_Rx),
    .rst_n         (rst_n),
    .byte_in       (byte_in),
    .byte_rdy      (byte_rdy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .busy          (busy),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk_Rx = ~clk_Rx;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: frame-level view of the byte stream.
  bit          m_prev_rdy = 0, m_strb = 0, m_in_frame = 0;
  logic [7:0]  m_buf[$];
  longint      m_cyc = 0, m_last = 0;
  bit          m_wr_en = 0, m_ferr = 0;
  logic [7:0]  m_addr = 0;
  logic [15:0] m_data = 0;
  logic [1:0]  m_code = 0;
  int          m_ok = 0, m_err = 0;

  always @(posedge clk_Rx or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_rdy = 0; m_in_frame = 0; m_buf.delete(); m_cyc = 0; m_last = 0;
      m_wr_en = 0; m_ferr = 0; m_addr = 0; m_data = 0; m_code = 0; m_ok = 0; m_err = 0;
    end else begin
      m_strb = byte_rdy && !m_prev_rdy;
      m_prev_rdy = byte_rdy;
      m_cyc++;
      m_wr_en = 0;
      m_ferr = 0;
      if (!m_in_frame) begin
        if (m_strb && byte_in == 8'hA5) begin
          m_in_frame = 1;
          m_buf.delete();
          m_last = m_cyc;
        end
      end else if (m_strb) begin
        m_buf.push_back(byte_in);
        m_last = m_cyc;
        if (m_buf.size() == 4) begin
          m_in_frame = 0;
          if ((m_buf[0] ^ m_buf[1] ^ m_buf[2]) == m_buf[3]) begin
            m_wr_en = 1; m_addr = m_buf[0]; m_data = {m_buf[1], m_buf[2]}; m_ok++;
          end else begin
            m_ferr = 1; m_code = 2'b01; m_err++;
          end
        end
      end else if (m_cyc - m_last == longint'(Tmo)) begin
        m_in_frame = 0; m_ferr = 1; m_code = 2'b10; m_err++;
      end
    end
  end

  always @(negedge clk_Rx) begin
    if (rst_n) begin
      check("wr_en", 32'(wr_en), 32'(m_wr_en));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("wr_addr", 32'(wr_addr), 32'(m_addr));
      check("wr_data", 32'(wr_data), 32'(m_data));
      check("err_code", 32'(err_code), 32'(m_code));
      check("busy", 32'(busy), 32'(m_in_frame));
      check("ok_cnt", 32'(frame_ok_cnt), 32'(m_ok % 16));
      check("err_cnt", 32'(frame_err_cnt), 32'((m_err > 15) ? 15 : m_err));
      if (wr_en) wr_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    byte_in = b;
    byte_rdy = 1'b1;
    repeat (hold) @(negedge clk_Rx);
    byte_rdy = 1'b0;
    repeat (gap) @(negedge clk_Rx);
  endtask

  task automatic send_frame(input logic [39:0] f, input int hold, input int gap);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8], hold, gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] fb[5];
  int         n, w0, e0, hold, gap, kind;
  bit         seen;

  initial begin
    repeat (3) @(negedge clk_Rx);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_counts", {frame_ok_cnt, frame_err_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_Rx);

    // Good frame, 20 cycles between strobes.
    send_byte(8'hA5, 1, 19); send_byte(8'h10, 1, 19);
    send_byte(8'h12, 1, 19); send_byte(8'h34, 1, 19);
    byte_in = 8'h36; byte_rdy = 1'b1;
    @(negedge clk_Rx);
    check("good_wr_en", 32'(wr_en), 1);
    check("good_addr", 32'(wr_addr), 32'h10);
    check("good_data", 32'(wr_data), 32'h1234);
    check("good_ok_cnt", 32'(frame_ok_cnt), 1);
    byte_rdy = 1'b0;
    @(negedge clk_Rx);
    check("good_pulse_end", 32'(wr_en), 0);
    repeat (18) @(negedge clk_Rx);

    // Bad checksum.
    send_byte(8'hA5, 1, 5); send_byte(8'h10, 1, 5);
    send_byte(8'h12, 1, 5); send_byte(8'h34, 1, 5);
    byte_in = 8'h37; byte_rdy = 1'b1;
    @(negedge clk_Rx);
    check("bad_ferr", 32'(frame_err), 1);
    check("bad_code", 32'(err_code), 1);
    check("bad_wr_en", 32'(wr_en), 0);
    check("bad_err_cnt", 32'(frame_err_cnt), 1);
    byte_rdy = 1'b0;
    @(negedge clk_Rx);
    check("bad_busy", 32'(busy), 0);
    repeat (5) @(negedge clk_Rx);

    // Timeout: error must rise 100 cycles after the ADDR strobe.
    send_byte(8'hA5, 1, 5);
    byte_in = 8'h10; byte_rdy = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 150) begin
      @(negedge clk_Rx);
      n++;
      byte_rdy = 1'b0;
      if (frame_err) seen = 1;
    end
    check("tmo_latency", n, 101);
    check("tmo_code", 32'(err_code), 2);
    check("tmo_busy", 32'(busy), 0);
    repeat (3) @(negedge clk_Rx);
    w0 = wr_cnt;
    send_frame(40'hA5_10_12_34_36, 1, 3);
    check("tmo_then_good", wr_cnt - w0, 1);

    // Held flag with leading garbage.
    w0 = wr_cnt;
    send_byte(8'h00, 3, 4); send_byte(8'hFF, 3, 4);
    send_frame(40'hA5_20_AB_CD_46, 3, 4);
    check("held_one_write", wr_cnt - w0, 1);
    check("held_addr", 32'(wr_addr), 32'h20);
    check("held_data", 32'(wr_data), 32'hABCD);

    // Asynchronous reset mid-frame.
    send_byte(8'hA5, 1, 4); send_byte(8'h10, 1, 4); send_byte(8'h12, 1, 4);
    @(posedge clk_Rx);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {15'd0, wr_en, wr_addr, frame_err, err_code, busy}, 0);
    check("arst_data", 32'(wr_data), 0);
    check("arst_counts", {frame_ok_cnt, frame_err_cnt}, 0);
    @(negedge clk_Rx);
    rst_n = 1'b1;
    @(negedge clk_Rx);
    w0 = wr_cnt;
    send_byte(8'h34, 1, 4); send_byte(8'h36, 1, 4);
    check("arst_tail_dropped", wr_cnt - w0, 0);
    send_frame(40'hA5_10_12_34_36, 1, 3);
    check("arst_then_good", wr_cnt - w0, 1);

    // Strobe exactly in the expiry cycle is accepted.
    w0 = wr_cnt; e0 = frame_err_cnt;
    send_frame(40'hA5_55_01_02_56, 1, 99);
    check("expiry_accept", wr_cnt - w0, 1);
    check("expiry_no_err", 32'(frame_err_cnt), 32'(e0));

    // Error counter saturates; ok counter wraps.
    for (int i = 0; i < 15; i++) send_frame(40'hA5_00_00_00_01, 1, 1);
    check("err_cnt_max", 32'(frame_err_cnt), 15);
    send_frame(40'hA5_00_00_00_01, 1, 1);
    send_frame(40'hA5_00_00_00_01, 1, 2);
    check("err_cnt_sat", 32'(frame_err_cnt), 15);
    for (int i = 0; i < 14; i++) send_frame(40'hA5_01_02_03_00, 1, 1);
    @(negedge clk_Rx);
    check("ok_cnt_wrap", 32'(frame_ok_cnt), 0);

    // Randomized traffic, including gaps around the timeout limit.
    for (int f = 0; f < 80; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        send_byte(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)),
                  int'($urandom_range(1, 10)));
      end else begin
        fb[0] = 8'hA5;
        fb[1] = 8'($urandom_range(0, 255));
        fb[2] = 8'($urandom_range(0, 255));
        fb[3] = 8'($urandom_range(0, 255));
        fb[4] = fb[1] ^ fb[2] ^ fb[3];
        if (kind <= 2) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
        for (int i = 0; i < 5; i++) begin
          hold = int'($urandom_range(1, 3));
          gap  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(97, 100))
                                              : int'($urandom_range(0, 25));
          send_byte(fb[i], hold, gap);
        end
      end
    end
    repeat (Tmo + 5) @(negedge clk_Rx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of the UART byte receiver in the frame register system, on the same clock as the receiver.
- Consumes received bytes and the receiver's byte-ready flag.
- Assembles fixed 5-byte command frames: SYNC, ADDR, DATA_H, DATA_L, CHK.
- Validates the XOR checksum and issues a single-cycle register write strobe.
- Reports checksum errors and inter-byte timeouts, and keeps frame/error counters for debug.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 2_000_000, max clk_Rx cycles allowed between byte strobes inside a frame (~20 ms at 100 MHz).
- CNT_W, 16, width of the frame_ok_cnt and frame_err_cnt counters.

Ports:
- clk_Rx  in  1  system clock, same domain as the UART receiver.
- rst_n  in  1  asynchronous, active-low reset.
- byte_in  in  8  received byte; stable while byte_rdy is high.
- byte_rdy  in  1  receiver byte-ready flag; may stay high for 1 or more cycles per byte.
- wr_en  out  1  one-cycle register write strobe.
- wr_addr  out  8  register address; valid while wr_en is high, held afterwards.
- wr_data  out  16  register data {DATA_H, DATA_L}; valid while wr_en is high, held afterwards.
- frame_err  out  1  one-cycle error pulse.
- err_code  out  2  01 = checksum error, 10 = timeout; valid with frame_err, held until the next error.
- busy  out  1  high in every state except IDLE.
- frame_ok_cnt  out  CNT_W  count of good frames; wraps to 0.
- frame_err_cnt  out  CNT_W  count of bad frames; saturates at all-ones.

Behaviour:
- Reset is asynchronous, active-low, one clock (clk_Rx). Assertion at any time, including mid-frame: state → IDLE; all outputs, counters, timer and internal regs → 0.
- Byte strobe: strb = byte_rdy & ~byte_rdy_q, where byte_rdy_q is a 1-cycle delayed copy (reset 0). Exactly one strobe per rising edge of byte_rdy, regardless of how long the flag is held.
- FSM states: IDLE, ADDR, DATH, DATL, CHK.
- IDLE: on strb with byte_in == SYNC_BYTE → ADDR. Any other byte is discarded silently, with no error.
- ADDR: on strb, latch addr_r, set chk_r = byte_in → DATH.
- DATH: on strb, latch dh_r, chk_r ^= byte_in → DATL.
- DATL: on strb, latch dl_r, chk_r ^= byte_in → CHK.
- CHK: on strb → IDLE.
  - If byte_in == chk_r: next cycle wr_en = 1, wr_addr = addr_r, wr_data = {dh_r, dl_r}, frame_ok_cnt += 1.
  - Else: next cycle frame_err = 1, err_code = 01, frame_err_cnt += 1 (saturating).
- No resync: SYNC_BYTE received in ADDR..CHK is treated as ordinary data.
- Latency: wr_en / frame_err rise exactly 1 cycle after the strb cycle of the CHK byte. Both are pulses of exactly 1 cycle.
- Timeout timer:
  - Cleared on every strb and in IDLE; increments each cycle in ADDR..CHK.
  - When it reaches TIMEOUT_CYC-1 with no strb in that cycle: → IDLE; next cycle frame_err = 1, err_code = 10, frame_err_cnt += 1. The partial frame is dropped.
  - A strb arriving in the same cycle as expiry wins: the byte is accepted and the timer clears.
- A strb in the cycle right after a frame completes is processed normally in IDLE. Back-to-back frames need no idle gap.
- wr_en and frame_err are never high in the same cycle.
- busy = (state != IDLE), registered with the state.
- Timer width: clog2(TIMEOUT_CYC)+1 bits, unsigned. No other arithmetic beyond 8-bit XOR and counter increments.

Decomposition:
- Package frame_pkg holds:
  - state encoding enum (IDLE, ADDR, DATH, DATL, CHK);
  - ERR_CHK = 2'b01 and ERR_TMO = 2'b10;
  - default SYNC_BYTE;
  - FRAME_LEN = 5.
- Sub-module rx_byte_strobe: rising-edge detector on byte_rdy, with async active-low reset. Output strb.
- Everything else (FSM, timer, counters) lives in uart_frame_parser.

Test Plan:
- Bench uses TIMEOUT_CYC = 100.
- Good frame: send A5 10 12 34 36 with 1-cycle byte_rdy pulses, 20 cycles apart → one wr_en pulse 1 cycle after the 36 strobe; wr_addr = 0x10, wr_data = 0x1234; frame_ok_cnt = 1; frame_err never high.
- Bad checksum: send A5 10 12 34 37 → frame_err pulse with err_code = 01; no wr_en; frame_err_cnt = 1; busy = 0 afterwards.
- Timeout: send A5 10, then hold byte_rdy low → frame_err with err_code = 10 exactly 100 cycles after the 10 strobe; state IDLE. Then send a good frame → accepted.
- Held strobe and garbage: send 00 FF, then A5 20 AB CD (chk = 0x20^0xAB^0xCD = 0x46) 46, each with byte_rdy held 3 cycles → one wr_en, wr_addr = 0x20, wr_data = 0xABCD; leading 00 FF ignored.
- Reset mid-frame: send A5 10 12, pull rst_n low asynchronously between clock edges → all outputs 0 immediately. Release and send 34 36 → no wr_en. Then a full good frame → wr_en.
- Boundary: strobe lands in the expiry cycle (99 cycles after the previous strobe) → no timeout, byte accepted. Also drive frame_err_cnt to its max value → it saturates and does not wrap.
